net_in_loader: RTL and testbench

Upstream feeder for the fixed-point linear network. Accepts a serial stream of signed WIDTH-bit samples with a valid/ready handshake, assembles NIN consecutive samples into one input vector, and presents that vector in parallel, held stable, to the combinational network's `in` port until the consumer acknowledges it. It also aligns frames: short frames are zero-padded, long frames are truncated, and both conditions are flagged.

---
 rtl/net_in_loader.sv | 109 ++++++++++
 tb/tb_net_in_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/net_in_loader.sv
// rtl/net_in_loader.sv - serial-to-parallel vector loader with frame alignment
// Collects NIN samples per frame, pads short frames, truncates long ones.
module net_in_loader #(
  parameter int WIDTH = 16,
  parameter int NIN   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic signed [WIDTH-1:0] vec_out [0:NIN-1],
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic                    short_err,
  output logic                    long_err
);

  localparam int IW = $clog2(NIN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIN - 1);

  typedef enum logic [1:0] {FILL, HOLD, DROP} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          pend, pend_nxt;
  logic          valid_nxt, short_nxt, long_nxt;
  logic          store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      idx       <= '0;
      pend      <= 1'b0;
      vec_valid <= 1'b0;
      short_err <= 1'b0;
      long_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      pend      <= pend_nxt;
      vec_valid <= valid_nxt;
      short_err <= short_nxt;
      long_err  <= long_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pend_nxt  = pend;
    valid_nxt = vec_valid;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    store     = 1'b0;
    s_ready   = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          store = 1'b1;
          if (idx != LAST_IDX) begin
            if (s_last) begin
              short_nxt = 1'b1;
              state_nxt = HOLD;
              idx_nxt   = '0;
              valid_nxt = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            // Vector full without s_last: the rest of this frame must be discarded.
            state_nxt = HOLD;
            idx_nxt   = '0;
            valid_nxt = 1'b1;
            long_nxt  = !s_last;
            pend_nxt  = !s_last;
          end
        end
      end
      HOLD: begin
        if (vec_ready) begin
          valid_nxt = 1'b0;
          pend_nxt  = 1'b0;
          state_nxt = pend ? DROP : FILL;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Short frames zero the tail in the same cycle as the final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NIN; i++) vec_out[i] <= '0;
    end else if (store) begin
      for (int i = 0; i < NIN; i++) begin
        if (i == int'(idx)) vec_out[i] <= s_data;
        else if (s_last && i > int'(idx)) vec_out[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_net_in_loader.sv
// tb/tb_net_in_loader.sv - bench for net_in_loader against a frame-level model
module tb_net_in_loader;
  localparam int WIDTH = 16;
  localparam int NIN   = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_valid, s_last, s_ready;
  logic signed [WIDTH-1:0] vec_out [0:NIN-1];
  logic                    vec_valid, vec_ready, short_err, long_err;

  net_in_loader #(.WIDTH(WIDTH), .NIN(NIN)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .vec_out(vec_out), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .short_err(short_err), .long_err(long_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model: a queue of the current frame's samples and the last presented vector.
  int m_buf[$];
  int m_vec [0:NIN-1];
  bit m_valid, m_short, m_long, m_dropping, m_drop_after;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    for (int i = 0; i < NIN; i++) m_vec[i] = 0;
    m_valid = 0; m_short = 0; m_long = 0; m_dropping = 0; m_drop_after = 0;
  endtask

  task automatic model_step(input int d, input bit v, input bit l, input bit vr);
    m_short = 0;
    m_long  = 0;
    if (m_valid) begin
      if (vr) begin
        m_valid    = 0;
        m_dropping = m_drop_after;
      end
    end else if (v) begin
      if (m_dropping) begin
        if (l) m_dropping = 0;
      end else begin
        m_buf.push_back(d);
        if (l || m_buf.size() == NIN) begin
          for (int i = 0; i < NIN; i++) m_vec[i] = (i < m_buf.size()) ? m_buf[i] : 0;
          m_short      = (m_buf.size() < NIN);
          m_long       = !l;
          m_drop_after = !l;
          m_valid      = 1;
          m_buf.delete();
        end
      end
    end
  endtask

  task automatic compare();
    chk("s_ready", int'(s_ready), int'(!m_valid));
    chk("vec_valid", int'(vec_valid), int'(m_valid));
    chk("short_err", int'(short_err), int'(m_short));
    chk("long_err", int'(long_err), int'(m_long));
    if (m_valid)
      for (int i = 0; i < NIN; i++) chk($sformatf("vec_out[%0d]", i), int'(vec_out[i]), m_vec[i]);
  endtask

  // One clock: drive at negedge, model advances at posedge, compare at next negedge.
  task automatic cyc(input int d, input bit v, input bit l, input bit vr);
    s_data = WIDTH'(d); s_valid = v; s_last = l; vec_ready = vr;
    @(posedge clk);
    model_step(d, v, l, vr);
    @(negedge clk);
    compare();
  endtask

  task automatic lit_vec(input string nm, input int a, input int b, input int c, input int e);
    chk({nm, "[0]"}, int'(vec_out[0]), a);
    chk({nm, "[1]"}, int'(vec_out[1]), b);
    chk({nm, "[2]"}, int'(vec_out[2]), c);
    chk({nm, "[3]"}, int'(vec_out[3]), e);
  endtask

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 0; s_last = 0; vec_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    compare();
    chk("reset_s_ready", int'(s_ready), 1);
    lit_vec("reset_vec", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Nominal frame
    cyc(-200, 1, 0, 1); cyc(35, 1, 0, 1); cyc(77, 1, 0, 1); cyc(-256, 1, 1, 1);
    chk("nom_valid", int'(vec_valid), 1);
    chk("nom_s_ready", int'(s_ready), 0);
    lit_vec("nom_vec", -200, 35, 77, -256);
    cyc(0, 0, 0, 1);
    chk("nom_valid_drop", int'(vec_valid), 0);
    chk("nom_s_ready_back", int'(s_ready), 1);

    // Backpressure: upstream keeps offering the next frame's first sample
    cyc(-200, 1, 0, 0); cyc(35, 1, 0, 0); cyc(77, 1, 0, 0); cyc(-256, 1, 1, 0);
    for (int k = 0; k < 5; k++) cyc(11, 1, 0, 0);
    chk("bp_held", int'(vec_valid), 1);
    lit_vec("bp_vec", -200, 35, 77, -256);
    cyc(11, 1, 0, 1);
    chk("bp_released", int'(vec_valid), 0);
    cyc(11, 1, 0, 1); cyc(12, 1, 0, 1); cyc(13, 1, 0, 1); cyc(14, 1, 1, 1);
    lit_vec("bp_next_vec", 11, 12, 13, 14);
    cyc(0, 0, 0, 1);

    // Short frame
    cyc(308, 1, 0, 0); cyc(-78, 1, 1, 0);
    chk("short_pulse", int'(short_err), 1);
    lit_vec("short_vec", 308, -78, 0, 0);
    cyc(0, 0, 0, 1);
    chk("short_once", int'(short_err), 0);

    // Long frame: tail dropped, next frame starts at index 0
    cyc(30, 1, 0, 1); cyc(780, 1, 0, 1); cyc(-25, 1, 0, 1); cyc(-77, 1, 0, 1);
    chk("long_pulse", int'(long_err), 1);
    lit_vec("long_vec", 30, 780, -25, -77);
    cyc(5, 1, 0, 1);
    chk("long_once", int'(long_err), 0);
    cyc(5, 1, 0, 1); cyc(6, 1, 1, 1);
    chk("long_drop_valid", int'(vec_valid), 0);
    cyc(1, 1, 0, 1); cyc(2, 1, 0, 1); cyc(3, 1, 0, 1); cyc(4, 1, 1, 0);
    lit_vec("after_long_vec", 1, 2, 3, 4);
    cyc(0, 0, 0, 1);

    // Reset mid-fill
    cyc(91, 1, 0, 1); cyc(92, 1, 0, 1);
    s_valid = 0; rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    lit_vec("midrst_vec", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(-1, 1, 0, 1); cyc(-2, 1, 0, 1); cyc(-3, 1, 0, 1); cyc(-4, 1, 1, 0);
    lit_vec("midrst_next_vec", -1, -2, -3, -4);
    cyc(0, 0, 0, 1);

    // Input stall: valid on alternate cycles, s_last offered while invalid too
    for (int k = 0; k < 8; k++) cyc(100 + k, (k % 2) == 0, (k == 6) || (k % 2 == 1), 0);
    chk("stall_valid", int'(vec_valid), 1);
    lit_vec("stall_vec", 100, 102, 104, 106);
    cyc(0, 0, 0, 1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      int d;
      d = $signed(16'($urandom));
      cyc(d, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
